cfg_chain_loader: RTL and testbench
===================================

Name: cfg_chain_loader

Overview:
Sequences the synapse configuration daisy chain. The chain is NUM_SYN synapses with REGS_PER_SYN word registers each, shifted on rising edges of a shared data clock, so it behaves as an L = NUM_SYN*REGS_PER_SYN word deep shift FIFO.
- Buffers L host words, then generates cfg_data_clk and cfg_data_out to shift them into the chain.
- Optionally performs a second, non-destructive shift pass that compares the chain return against the buffer.
- Sits between the host/config bus and the head of the synapse chain; the chain tail feeds cfg_data_return.

Parameters:
WORD_WIDTH, fp::WORD_LENGTH, config word width
NUM_SYN, 8, synapses in chain
REGS_PER_SYN, 3, chain registers per synapse
CLK_DIV, 4, clk cycles per half period of cfg_data_clk (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  begin a load sequence (pulse; honoured only in IDLE)
verify_en  in  1  sampled with start; 1 = run verify pass after load
wr_valid  in  1  host word valid
wr_data  in  WORD_WIDTH  host word
wr_ready  out  1  high only in FILL
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at end of sequence
error  out  1  sticky verify mismatch, cleared by accepted start or reset
mismatch_idx  out  clog2(L)  index of first mismatching word, valid when error=1
cfg_data_clk  out  1  chain shift clock, registered
cfg_data_out  out  WORD_WIDTH  word to chain head, registered
cfg_data_return  in  WORD_WIDTH  chain tail output

Behaviour:
- Reset: state IDLE; all outputs 0; word counter and phase counter 0. Reset mid-sequence drops cfg_data_clk to 0 on the next edge; partial chain contents are not restored.
- Buffer: L x WORD_WIDTH register array. Word k is written at index k.
- FSM:
  - IDLE: on start, latch verify_en, clear error/mismatch_idx, go to FILL. start in any other state is ignored.
  - FILL: wr_ready=1. A word is accepted when wr_valid&&wr_ready. After the L-th word, go to SETUP with pass=LOAD, k=0. Host gaps (wr_valid=0) simply stall.
  - SETUP: cfg_data_out=buf[k]; cfg_data_clk=0 for CLK_DIV cycles. On the last SETUP cycle with pass=VERIFY, compare cfg_data_return with buf[k]. On a mismatch with error still 0, set error=1 and mismatch_idx=k. Then go to HIGH.
  - HIGH: cfg_data_clk=1 for CLK_DIV cycles; cfg_data_out is held. Then:
    - if k<L-1: k++ and go to SETUP;
    - else if pass=LOAD and verify latched: pass=VERIFY, k=0, go to SETUP;
    - else go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Timing: each shift takes exactly 2*CLK_DIV clk cycles. A load-only sequence takes L*2*CLK_DIV cycles from the cycle after the last FILL accept to DONE; verify doubles this.
- Verify principle: after the LOAD pass the chain holds buf. Just before the k-th VERIFY rising edge, the tail shows buf[k]. Re-pushing buf[k] leaves the chain unchanged.
- Only the first mismatch is recorded; the sequence always completes all shifts.
- cfg_data_out changes only in the first SETUP cycle, giving CLK_DIV cycles of setup and hold around each rising edge.

Decomposition:
- fp package: WORD_LENGTH and fpType are reused. Add to a shared cfg package: the FSM state enum (IDLE, FILL, SETUP, HIGH, DONE), the pass enum (LOAD, VERIFY), and a chain length function L(NUM_SYN, REGS_PER_SYN).
- Sub-module cfg_phase_gen: CLK_DIV phase counter with start/clear input, emitting last_setup and last_high strobes.

Test Plan:
- NUM_SYN=2, REGS_PER_SYN=3, CLK_DIV=2, verify_en=0, words 0x0101..0x0106 → exactly 6 cfg_data_clk rising edges spaced 4 cycles apart; behavioural chain model holds 0x0101 at tail; done pulses 24 cycles after last accept; error=0.
- Same words with verify_en=1 and a correct chain model → 12 rising edges; error=0; chain contents unchanged after done.
- verify_en=1, chain model forces register holding word 3 to 0xDEAD → error=1, mismatch_idx=3 sticky after done; next start clears error.
- FILL with wr_valid gaps of 0–3 cycles, plus a start asserted while busy → all 6 words accepted in order, stray start ignored, one done pulse.
- Reset asserted during a HIGH phase of shift 2 → next cycle cfg_data_clk=0, busy=0, done=0; a fresh start then completes normally.
- CLK_DIV=1 corner: alternate-cycle cfg_data_clk toggling; cfg_data_out stable across every rising edge.

Source files
------------

// File: rtl/cfg_chain_loader_pkg.sv
// cfg_chain_loader_pkg: shared types and helpers for the synapse config chain loader.
// Provides the loader FSM state enum, the shift pass enum and the chain length function.
package cfg_chain_loader_pkg;
  typedef enum logic [2:0] {IDLE, FILL, SETUP, HIGH, DONE} state_t;
  typedef enum logic {LOAD, VERIFY} pass_t;
  function automatic int chain_len(input int num_syn, input int regs_per_syn);
    return num_syn * regs_per_syn;
  endfunction
endpackage

// File: rtl/fp.sv
// fp: shared fixed-point word definitions.
// WORD_LENGTH is the config/data word width used across the codebase; fpType is the matching word type.
package fp;
  localparam int WORD_LENGTH = 16;
  typedef logic signed [WORD_LENGTH-1:0] fpType;
endpackage

// File: rtl/cfg_phase_gen.sv
// cfg_phase_gen: CLK_DIV phase counter that times the SETUP and HIGH halves of each chain shift.
// Ports: clk, reset (sync, active-high); run (0 clears the counter), high (current half is HIGH);
// last_setup / last_high strobe on the final cycle of the corresponding half.
module cfg_phase_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic high,
  output logic last_setup,
  output logic last_high
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(CLK_DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic last;
  // Each half is exactly CLK_DIV cycles, so wrapping on the last cycle keeps the
  // counter aligned for the next half without any explicit restart.
  always_comb begin
    last = cnt_q == TOP;
    cnt_d = (!run || last) ? '0 : cnt_q + 1'b1;
    last_setup = run && !high && last;
    last_high = run && high && last;
  end
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: buffers L host words and shifts them into the synapse config chain, with optional verify pass.
// Ports: clk, reset (sync, active-high); start/verify_en begin a sequence; wr_valid/wr_data/wr_ready host
// word input; busy, done (1-cycle pulse), error/mismatch_idx (sticky first verify mismatch);
// cfg_data_clk/cfg_data_out drive the chain head, cfg_data_return is the chain tail.
module cfg_chain_loader
  import cfg_chain_loader_pkg::*;
#(
  parameter int WORD_WIDTH = fp::WORD_LENGTH,
  parameter int NUM_SYN = 8,
  parameter int REGS_PER_SYN = 3,
  parameter int CLK_DIV = 4,
  localparam int L = chain_len(NUM_SYN, REGS_PER_SYN),
  localparam int IW = $clog2(L)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  verify_en,
  input  logic                  wr_valid,
  input  logic [WORD_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [IW-1:0]         mismatch_idx,
  output logic                  cfg_data_clk,
  output logic [WORD_WIDTH-1:0] cfg_data_out,
  input  logic [WORD_WIDTH-1:0] cfg_data_return
);
  localparam logic [IW-1:0] LAST = IW'(L - 1);
  state_t state_q, state_d;
  pass_t pass_q, pass_d;
  logic verify_q, verify_d;
  logic [IW-1:0] k_q, k_d;
  logic [WORD_WIDTH-1:0] wbuf_q [L];
  logic [WORD_WIDTH-1:0] wbuf_d [L];
  logic error_q, error_d;
  logic [IW-1:0] mismatch_idx_q, mismatch_idx_d;
  logic cfg_data_clk_q, cfg_data_clk_d;
  logic [WORD_WIDTH-1:0] cfg_data_out_q, cfg_data_out_d;
  logic last_setup, last_high;
  cfg_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk       (clk),
    .reset     (reset),
    .run       (state_q == SETUP || state_q == HIGH),
    .high      (state_q == HIGH),
    .last_setup(last_setup),
    .last_high (last_high)
  );
  always_comb begin
    state_d = state_q;
    pass_d = pass_q;
    verify_d = verify_q;
    k_d = k_q;
    wbuf_d = wbuf_q;
    error_d = error_q;
    mismatch_idx_d = mismatch_idx_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FILL;
        verify_d = verify_en;
        error_d = 1'b0;
        mismatch_idx_d = '0;
        k_d = '0;
      end
      FILL: if (wr_valid) begin
        wbuf_d[k_q] = wr_data;
        k_d = k_q == LAST ? '0 : k_q + 1'b1;
        state_d = k_q == LAST ? SETUP : FILL;
        pass_d = LOAD;
      end
      // After the load pass the tail shows buf[k] just before the k-th verify edge.
      SETUP: if (last_setup) begin
        if (pass_q == VERIFY && cfg_data_return != wbuf_q[k_q] && !error_q) begin
          error_d = 1'b1;
          mismatch_idx_d = k_q;
        end
        state_d = HIGH;
      end
      HIGH: if (last_high) begin
        if (k_q != LAST) begin
          k_d = k_q + 1'b1;
          state_d = SETUP;
        end else if (pass_q == LOAD && verify_q) begin
          pass_d = VERIFY;
          k_d = '0;
          state_d = SETUP;
        end else begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Both chain outputs are registered from the next state so they align with it;
    // the data word only moves on SETUP entry, keeping it stable around the rising edge.
    cfg_data_clk_d = state_d == HIGH;
    cfg_data_out_d = (state_d == SETUP && state_q != SETUP) ? wbuf_q[k_d] : cfg_data_out_q;
  end
  always_ff @(posedge clk) begin
    wbuf_q <= wbuf_d;
    if (reset) begin
      state_q <= IDLE;
      pass_q <= LOAD;
      verify_q <= 1'b0;
      k_q <= '0;
      error_q <= 1'b0;
      mismatch_idx_q <= '0;
      cfg_data_clk_q <= 1'b0;
      cfg_data_out_q <= '0;
    end else begin
      state_q <= state_d;
      pass_q <= pass_d;
      verify_q <= verify_d;
      k_q <= k_d;
      error_q <= error_d;
      mismatch_idx_q <= mismatch_idx_d;
      cfg_data_clk_q <= cfg_data_clk_d;
      cfg_data_out_q <= cfg_data_out_d;
    end
  end
  assign wr_ready = state_q == FILL;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign error = error_q;
  assign mismatch_idx = mismatch_idx_q;
  assign cfg_data_clk = cfg_data_clk_q;
  assign cfg_data_out = cfg_data_out_q;
endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader: directed bench for cfg_chain_loader (L=6) with behavioural chain models, CLK_DIV=2 and CLK_DIV=1.
module tb_cfg_chain_loader;
  localparam int W = 16;
  localparam int L = 6;
  logic clk = 0, reset = 1, start = 0, verify_en = 0, wr_valid = 0;
  logic [W-1:0] wr_data = '0;
  logic wr_ready, busy, done, error, cfg_data_clk;
  logic [2:0] mismatch_idx;
  logic [W-1:0] cfg_data_out, ret;
  logic wr_ready1, busy1, done1, error1, clk1;
  logic [2:0] idx1;
  logic [W-1:0] out1, ret1;
  logic [W-1:0] ch [L] = '{default: '0};
  logic [W-1:0] ch1 [L] = '{default: '0};
  int vectors = 0, miscompares = 0;
  int cyc = 0, ce = 0, corrupt_at = -1;
  int edges = 0, last_e = -1, bad = 0, dones = 0;
  logic prev_clk = 0;
  cfg_chain_loader #(.WORD_WIDTH(W), .NUM_SYN(2), .REGS_PER_SYN(3), .CLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .start(start), .verify_en(verify_en), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready), .busy(busy), .done(done), .error(error),
    .mismatch_idx(mismatch_idx), .cfg_data_clk(cfg_data_clk), .cfg_data_out(cfg_data_out),
    .cfg_data_return(ret)
  );
  cfg_chain_loader #(.WORD_WIDTH(W), .NUM_SYN(2), .REGS_PER_SYN(3), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .verify_en(verify_en), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready1), .busy(busy1), .done(done1), .error(error1),
    .mismatch_idx(idx1), .cfg_data_clk(clk1), .cfg_data_out(out1),
    .cfg_data_return(ret1)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // Chain models: L-deep word shift registers clocked by cfg_data_clk; optional one-shot upset of register 2.
  always @(posedge cfg_data_clk) begin
    for (int i = L - 1; i > 0; i--) ch[i] <= ch[i-1];
    ch[0] <= cfg_data_out;
    if (ce + 1 == corrupt_at) ch[2] <= 16'hDEAD;
    ce <= ce + 1;
  end
  always @(posedge clk1) begin
    for (int i = L - 1; i > 0; i--) ch1[i] <= ch1[i-1];
    ch1[0] <= out1;
  end
  assign ret = ch[L-1];
  assign ret1 = ch1[L-1];
  // Edge monitor: counts rising edges of cfg_data_clk and spacing errors within a sequence.
  always @(negedge clk) begin
    if (!busy) last_e = -1;
    if (cfg_data_clk && !prev_clk) begin
      if (last_e >= 0 && cyc - last_e != 4) bad++;
      last_e = cyc;
      edges++;
    end
    prev_clk = cfg_data_clk;
    if (done) dones++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic start_seq(input logic v);
    start = 1;
    verify_en = v;
    @(negedge clk);
    start = 0;
    verify_en = 0;
  endtask
  task automatic send(input logic [W-1:0] w, input int gap, input logic stray);
    int n;
    wr_valid = 0;
    for (int g = 0; g < gap; g++) begin
      start = stray && g == 0;
      verify_en = stray;
      @(negedge clk);
    end
    start = 0;
    verify_en = 0;
    wr_valid = 1;
    wr_data = w;
    n = 0;
    while (!wr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wr_ready", wr_ready, 1);
    @(negedge clk);
    wr_valid = 0;
  endtask
  task automatic fill(input logic gaps, input logic stray);
    for (int k = 0; k < L; k++) send(W'(32'h0101 + k), gaps ? k % 4 : 0, stray && k == 2);
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", done, 1);
  endtask
  task automatic check_chain();
    for (int k = 0; k < L; k++) check("chain", ch[L-1-k], 32'h0101 + k);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    int lat, e0, b0, d0, n, guard;
    logic p;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", wr_ready, 0);
    check("rst_error", error, 0);
    check("rst_idx", mismatch_idx, 0);
    check("rst_dclk", cfg_data_clk, 0);
    check("rst_dout", cfg_data_out, 0);
    reset = 0;
    @(negedge clk);
    // Load only; dut1 (CLK_DIV=1) runs the same stream in lock-step.
    e0 = edges;
    b0 = bad;
    start_seq(0);
    fill(0, 0);
    for (int i = 0; i < 12; i++) begin
      check("d1_clk", clk1, i % 2);
      check("d1_out", out1, 32'h0101 + i / 2);
      @(negedge clk);
    end
    check("d1_done", done1, 1);
    wait_done(lat);
    check("load_latency", lat + 12, 24);
    check("load_edges", edges - e0, 6);
    check("load_spacing", bad - b0, 0);
    check("load_tail", ret, 16'h0101);
    check("d1_tail", ret1, 16'h0101);
    check("load_error", error, 0);
    @(negedge clk);
    // Load + verify against a correct chain.
    e0 = edges;
    b0 = bad;
    start_seq(1);
    fill(0, 0);
    wait_done(lat);
    check("ver_latency", lat, 48);
    check("ver_edges", edges - e0, 12);
    check("ver_spacing", bad - b0, 0);
    check("ver_error", error, 0);
    check_chain();
    @(negedge clk);
    // Verify with word 3 upset after the load pass.
    corrupt_at = ce + 6;
    start_seq(1);
    fill(0, 0);
    wait_done(lat);
    check("bad_error", error, 1);
    check("bad_idx", mismatch_idx, 3);
    repeat (3) @(negedge clk);
    check("bad_error_sticky", error, 1);
    check("bad_idx_sticky", mismatch_idx, 3);
    corrupt_at = -1;
    // Host gaps plus stray starts; the accepted start clears error.
    e0 = edges;
    d0 = dones;
    start_seq(0);
    check("error_clr", error, 0);
    check("idx_clr", mismatch_idx, 0);
    fill(1, 1);
    start = 1;
    verify_en = 1;
    @(negedge clk);
    start = 0;
    verify_en = 0;
    wait_done(lat);
    repeat (10) @(negedge clk);
    check("gap_dones", dones - d0, 1);
    check("gap_edges", edges - e0, 6);
    check("gap_busy", busy, 0);
    check_chain();
    // Reset during the HIGH phase of shift 2.
    start_seq(0);
    fill(0, 0);
    n = 0;
    p = cfg_data_clk;
    guard = 0;
    while (n < 2 && guard < 200) begin
      @(negedge clk);
      if (cfg_data_clk && !p) n++;
      p = cfg_data_clk;
      guard++;
    end
    check("rst_mid_reached", n, 2);
    reset = 1;
    @(negedge clk);
    check("rst_mid_dclk", cfg_data_clk, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    reset = 0;
    @(negedge clk);
    e0 = edges;
    start_seq(0);
    fill(0, 0);
    wait_done(lat);
    check("post_rst_latency", lat, 24);
    check("post_rst_edges", edges - e0, 6);
    check("post_rst_error", error, 0);
    check_chain();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
